// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the frame sync lock block: state encoding,
// counter width and the saturating increment used by the hit/miss counters.
package frame_sync_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCK    = 2'd2
  } sync_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/frame_slot_cnt.sv
// Slot position counter within a frame; wraps FRAME_LEN-1 -> 0.
// clr_to_0 has priority over clr_to_1, which has priority over en.
module frame_slot_cnt #(
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr_to_1,
  input  logic       clr_to_0,
  output logic [7:0] slot
);

  localparam logic [7:0] LAST_SLOT = 8'(FRAME_LEN - 1);

  logic [7:0] slot_d;
  logic [7:0] slot_q;

  // Next slot value selection
  always_comb begin
    slot_d = slot_q;
    if (clr_to_0) begin
      slot_d = 8'd0;
    end else if (clr_to_1) begin
      slot_d = 8'd1;
    end else if (en) begin
      if (slot_q == LAST_SLOT) begin
        slot_d = 8'd0;
      end else begin
        slot_d = slot_q + 8'd1;
      end
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 8'd0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/frame_sync_lock.sv
// Frame synchroniser: searches for SYNC_WORD, confirms it at the frame period,
// then tracks lock, tolerating up to MISS_N-1 consecutive missed sync slots.
module frame_sync_lock
  import frame_sync_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(8'hF7),
  parameter int                FRAME_LEN = 16,
  parameter int                CONFIRM_N = 3,
  parameter int                MISS_N    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              syn_out_flag,
  output logic              locked,
  output logic [1:0]        sync_state,
  output logic [7:0]        slot
);

  localparam logic [CNT_W-1:0] CONFIRM_TH = CNT_W'(CONFIRM_N);
  localparam logic [CNT_W-1:0] MISS_TH    = CNT_W'(MISS_N);

  sync_state_e      state_d, state_q;
  logic [CNT_W-1:0] hit_d, hit_q;
  logic [CNT_W-1:0] miss_d, miss_q;
  logic             flag_d, flag_q;
  logic             locked_d, locked_q;
  logic             slot_en_s, slot_clr1_s, slot_clr0_s;
  logic             match_s, in_slot_s;
  logic [CNT_W-1:0] hit_inc_s, miss_inc_s;

  assign match_s    = (data == SYNC_WORD);
  assign in_slot_s  = (slot == 8'd0);
  assign hit_inc_s  = sat_inc(hit_q);
  assign miss_inc_s = sat_inc(miss_q);

  // Next-state, counter and slot-control decode
  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    flag_d      = 1'b0;
    slot_en_s   = 1'b0;
    slot_clr1_s = 1'b0;
    slot_clr0_s = 1'b0;
    if (data_valid) begin
      case (state_q)
        SEARCH: begin
          if (match_s) begin
            slot_clr1_s = 1'b1;
            hit_d       = {CNT_W{1'b0}};
            state_d     = CONFIRM;
          end else begin
            slot_clr0_s = 1'b1;
          end
        end
        CONFIRM: begin
          if (in_slot_s && match_s) begin
            hit_d     = hit_inc_s;
            slot_en_s = 1'b1;
            if (hit_inc_s >= CONFIRM_TH) begin
              state_d = LOCK;
              miss_d  = {CNT_W{1'b0}};
              flag_d  = 1'b1;
            end else begin
              state_d = CONFIRM;
            end
          end else if (in_slot_s) begin
            state_d     = SEARCH;
            slot_clr0_s = 1'b1;
          end else begin
            slot_en_s = 1'b1;
          end
        end
        LOCK: begin
          if (in_slot_s && match_s) begin
            flag_d    = 1'b1;
            miss_d    = {CNT_W{1'b0}};
            slot_en_s = 1'b1;
          end else if (in_slot_s) begin
            miss_d = miss_inc_s;
            if (miss_inc_s >= MISS_TH) begin
              state_d     = SEARCH;
              slot_clr0_s = 1'b1;
            end else begin
              slot_en_s = 1'b1;
            end
          end else begin
            slot_en_s = 1'b1;
          end
        end
        default: begin
          state_d     = SEARCH;
          slot_clr0_s = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == LOCK);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      hit_q    <= {CNT_W{1'b0}};
      miss_q   <= {CNT_W{1'b0}};
      flag_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      flag_q   <= flag_d;
      locked_q <= locked_d;
    end
  end

  frame_slot_cnt #(
    .FRAME_LEN (FRAME_LEN)
  ) u_slot_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (slot_en_s),
    .clr_to_1 (slot_clr1_s),
    .clr_to_0 (slot_clr0_s),
    .slot     (slot)
  );

  assign syn_out_flag = flag_q;
  assign locked       = locked_q;
  assign sync_state   = state_q;

endmodule
